// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared register-select encoding and control-bit layout for the
//            multi-channel PWM bank.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

   // Low two address bits select the register within a channel
   typedef enum logic [1:0] {
      SEL_PERIOD = 2'd0,
      SEL_DUTY   = 2'd1,
      SEL_CTRL   = 2'd2,
      SEL_RSVD   = 2'd3
   } sel_e;

   // Bit positions inside the control register
   localparam int CTRL_EN  = 0;
   localparam int CTRL_INV = 1;

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_channel
// Purpose  : One PWM channel with double-buffered period/duty, enable and
//            output invert; produces a registered output and period tick.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             resetq,
   input  logic             wr_period,
   input  logic             wr_duty,
   input  logic             wr_ctrl,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] period_s,
   output logic [WIDTH-1:0] duty_s,
   output logic             en,
   output logic             inv,
   output logic             out,
   output logic             tick
);

   logic [WIDTH-1:0] period_a;
   logic [WIDTH-1:0] duty_a;
   logic [WIDTH-1:0] cnt;

   logic [WIDTH-1:0] period_s_n;
   logic [WIDTH-1:0] duty_s_n;
   logic [WIDTH-1:0] period_a_n;
   logic [WIDTH-1:0] duty_a_n;
   logic [WIDTH-1:0] cnt_n;
   logic             en_n;
   logic             inv_n;
   logic             load;
   logic             run_n;
   logic             out_n;
   logic             tick_n;

   // Next-state: shadow writes, active reload at period boundaries, counting.
   // The reload also fires on the enabling and disabling edges so a fresh
   // enable starts at cnt=0 and a disabled channel parks its counter at 0.
   // Shadow next-values feed the reload so a coincident write goes straight in.
   always_comb begin
      period_s_n = wr_period ? wdata : period_s;
      duty_s_n   = wr_duty   ? wdata : duty_s;
      en_n       = wr_ctrl   ? wdata[CTRL_EN]  : en;
      inv_n      = wr_ctrl   ? wdata[CTRL_INV] : inv;

      load = !en || !en_n || (period_a == '0) ||
             (cnt == (period_a - WIDTH'(1)));

      period_a_n = load ? period_s_n : period_a;
      duty_a_n   = load ? duty_s_n   : duty_a;
      cnt_n      = load ? '0         : (cnt + WIDTH'(1));

      run_n  = en_n && (period_a_n != '0);
      out_n  = inv_n ^ (run_n && (cnt_n < duty_a_n));
      tick_n = run_n && (cnt_n == '0);
   end

   // State and output registers; reset clears everything immediately
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         period_s <= '0;
         duty_s   <= '0;
         period_a <= '0;
         duty_a   <= '0;
         cnt      <= '0;
         en       <= 1'b0;
         inv      <= 1'b0;
         out      <= 1'b0;
         tick     <= 1'b0;
      end else begin
         period_s <= period_s_n;
         duty_s   <= duty_s_n;
         period_a <= period_a_n;
         duty_a   <= duty_a_n;
         cnt      <= cnt_n;
         en       <= en_n;
         inv      <= inv_n;
         out      <= out_n;
         tick     <= tick_n;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pwm_bank.sv
`default_nettype none
// ============================================================================
// Module   : pwm_bank
// Purpose  : Bank of NCH independent PWM channels on the CPU write bus with
//            address decode and combinational shadow-register readback.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_bank
   import pwm_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int WIDTH = 16,
   parameter int AW    = $clog2(NCH) + 2
) (
   input  logic             clk,
   input  logic             resetq,
   input  logic             wr,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [NCH-1:0]   out,
   output logic [NCH-1:0]   tick
);

   // Upper address bits pick the channel; out-of-range indices match nothing
   logic [AW-1:0] ch_idx;
   sel_e          sel;

   assign ch_idx = addr >> 2;
   assign sel    = sel_e'(addr[1:0]);

   logic [WIDTH-1:0] period_s [NCH];
   logic [WIDTH-1:0] duty_s   [NCH];
   logic [NCH-1:0]   en;
   logic [NCH-1:0]   inv;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic hit;
      assign hit = wr && (32'(ch_idx) == 32'(i));

      pwm_channel #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk       (clk),
         .resetq    (resetq),
         .wr_period (hit && (sel == SEL_PERIOD)),
         .wr_duty   (hit && (sel == SEL_DUTY)),
         .wr_ctrl   (hit && (sel == SEL_CTRL)),
         .wdata     (wdata),
         .period_s  (period_s[i]),
         .duty_s    (duty_s[i]),
         .en        (en[i]),
         .inv       (inv[i]),
         .out       (out[i]),
         .tick      (tick[i])
      );
   end

   // Readback mux of shadow registers; reserved select or absent channel reads 0
   always_comb begin
      rdata = '0;
      for (int i = 0; i < NCH; i++) begin
         if (32'(ch_idx) == 32'(i)) begin
            case (sel)
               SEL_PERIOD: rdata = period_s[i];
               SEL_DUTY:   rdata = duty_s[i];
               SEL_CTRL:   rdata = {{(WIDTH-2){1'b0}}, inv[i], en[i]};
               default:    rdata = '0;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_bank
// Purpose  : Directed self-checking bench for pwm_bank (NCH=4 plus an NCH=3
//            copy sharing the same bus for decode checks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_bank;

   localparam int WIDTH = 16;
   localparam int AW    = 4;

   logic             clk    = 1'b0;
   logic             resetq = 1'b0;
   logic             wr     = 1'b0;
   logic [AW-1:0]    addr   = '0;
   logic [WIDTH-1:0] wdata  = '0;
   logic [WIDTH-1:0] rdata;
   logic [WIDTH-1:0] rdata3;
   logic [3:0]       out;
   logic [3:0]       tick;
   logic [2:0]       out3;
   logic [2:0]       tick3;

   int n_assert = 0;
   int n_fail   = 0;

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   pwm_bank #(.NCH(4), .WIDTH(WIDTH)) dut (
      .clk    (clk),
      .resetq (resetq),
      .wr     (wr),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .out    (out),
      .tick   (tick)
   );

   pwm_bank #(.NCH(3), .WIDTH(WIDTH)) dut3 (
      .clk    (clk),
      .resetq (resetq),
      .wr     (wr),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata3),
      .out    (out3),
      .tick   (tick3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_reg(input int ch, input int sel, input logic [WIDTH-1:0] d);
      @(negedge clk);
      wr    = 1'b1;
      addr  = AW'((ch << 2) | sel);
      wdata = d;
      @(posedge clk);
      #1;
      wr = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input int ch, input int sel, input logic [31:0] exp);
      addr = AW'((ch << 2) | sel);
      #1;
      chk(tag, 32'(rdata), exp);
   endtask

   int per [4];
   int dut_d [4];
   int c;

   initial begin
      // ---------------- reset state ----------------
      #12;
      chk("rst_out", 32'(out), 0);
      chk("rst_tick", 32'(tick), 0);
      rd_chk("rst_p0", 0, 0, 0);
      @(negedge clk);
      resetq = 1'b1;

      // ---------------- basic PWM ch0 P=5 D=2 ----------------
      wr_reg(0, 0, 16'd5);
      wr_reg(0, 1, 16'd2);
      rd_chk("rb_p0", 0, 0, 5);
      rd_chk("rb_d0", 0, 1, 2);
      chk("dis_out0", 32'(out[0]), 0);
      wr_reg(0, 2, 16'd1);
      rd_chk("rb_c0", 0, 2, 1);
      for (int k = 0; k < 15; k++) begin
         chk($sformatf("basic_out[%0d]", k), 32'(out[0]), ((k % 5) < 2) ? 1 : 0);
         chk($sformatf("basic_tick[%0d]", k), 32'(tick[0]), ((k % 5) == 0) ? 1 : 0);
         if (k < 14) step();
      end

      // ---------------- glitch-free update ch1 ----------------
      wr_reg(1, 0, 16'd8);
      wr_reg(1, 1, 16'd4);
      wr_reg(1, 2, 16'd1);          // t=0
      wr_reg(1, 0, 16'd4);          // t=1
      wr_reg(1, 1, 16'd1);          // t=2
      for (int t = 2; t < 20; t++) begin
         if (t < 8) begin
            chk($sformatf("glitch_out[%0d]", t), 32'(out[1]), (t < 4) ? 1 : 0);
            chk($sformatf("glitch_tick[%0d]", t), 32'(tick[1]), 0);
         end else begin
            c = (t - 8) % 4;
            chk($sformatf("glitch_out[%0d]", t), 32'(out[1]), (c < 1) ? 1 : 0);
            chk($sformatf("glitch_tick[%0d]", t), 32'(tick[1]), (c == 0) ? 1 : 0);
         end
         if (t < 19) step();
      end

      // ---------------- edge duties ch2 ----------------
      wr_reg(2, 0, 16'd6);
      wr_reg(2, 1, 16'd0);
      wr_reg(2, 2, 16'd1);
      chk("d0_tick", 32'(tick[2]), 1);
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("d0_out[%0d]", k), 32'(out[2]), 0);
         step();
      end
      wr_reg(2, 2, 16'd0);
      wr_reg(2, 1, 16'd6);
      wr_reg(2, 2, 16'd1);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("dp_out[%0d]", k), 32'(out[2]), 1);
         chk($sformatf("dp_tick[%0d]", k), 32'(tick[2]), ((k % 6) == 0) ? 1 : 0);
         step();
      end
      wr_reg(2, 2, 16'd0);
      wr_reg(2, 0, 16'd1);
      wr_reg(2, 1, 16'd1);
      wr_reg(2, 2, 16'd1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("p1_out[%0d]", k), 32'(out[2]), 1);
         chk($sformatf("p1_tick[%0d]", k), 32'(tick[2]), 1);
         step();
      end
      wr_reg(2, 2, 16'd0);
      wr_reg(2, 0, 16'd0);
      wr_reg(2, 2, 16'd1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("p0_out[%0d]", k), 32'(out[2]), 0);
         chk($sformatf("p0_tick[%0d]", k), 32'(tick[2]), 0);
         step();
      end

      // ---------------- invert and disable ch3 ----------------
      wr_reg(3, 0, 16'd4);
      wr_reg(3, 1, 16'd1);
      wr_reg(3, 2, 16'd3);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("inv_out[%0d]", k), 32'(out[3]), ((k % 4) != 0) ? 1 : 0);
         chk($sformatf("inv_tick[%0d]", k), 32'(tick[3]), ((k % 4) == 0) ? 1 : 0);
         if (k < 7) step();
      end
      wr_reg(3, 2, 16'd2);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("hold_out[%0d]", k), 32'(out[3]), 1);
         chk($sformatf("hold_tick[%0d]", k), 32'(tick[3]), 0);
         step();
      end
      wr_reg(3, 2, 16'd0);
      chk("off_out", 32'(out[3]), 0);

      // ---------------- channel independence ----------------
      per[0] = 3; dut_d[0] = 1;
      per[1] = 5; dut_d[1] = 3;
      per[2] = 2; dut_d[2] = 1;
      per[3] = 7; dut_d[3] = 2;
      for (int i = 0; i < 4; i++) wr_reg(i, 2, 16'd0);
      for (int i = 0; i < 4; i++) begin
         wr_reg(i, 0, 16'(per[i]));
         wr_reg(i, 1, 16'(dut_d[i]));
      end
      for (int i = 0; i < 4; i++) wr_reg(i, 2, 16'd1);   // channel i enabled 3-i edges before t=0
      for (int t = 0; t < 14; t++) begin
         for (int i = 0; i < 4; i++) begin
            c = (t + 3 - i) % per[i];
            chk($sformatf("ind_out%0d[%0d]", i, t), 32'(out[i]), (c < dut_d[i]) ? 1 : 0);
            chk($sformatf("ind_tick%0d[%0d]", i, t), 32'(tick[i]), (c == 0) ? 1 : 0);
            if (i < 3)
               chk($sformatf("ind3_out%0d[%0d]", i, t), 32'(out3[i]), (c < dut_d[i]) ? 1 : 0);
         end
         step();
      end

      // ---------------- decode: reserved select, absent channel ----------------
      wr_reg(0, 3, 16'hABCD);
      rd_chk("rsv_p0", 0, 0, 3);
      rd_chk("rsv_d0", 0, 1, 1);
      rd_chk("rsv_c0", 0, 2, 1);
      rd_chk("rsv_r0", 0, 3, 0);
      wr_reg(3, 0, 16'h1234);
      rd_chk("ch3_p", 3, 0, 32'h1234);
      for (int i = 0; i < 3; i++) begin
         addr = AW'(i << 2);
         #1;
         chk($sformatf("nch3_p%0d", i), 32'(rdata3), 32'(per[i]));
      end
      addr = AW'(3 << 2);
      #1;
      chk("nch3_absent", 32'(rdata3), 0);

      // ---------------- asynchronous reset mid-run ----------------
      wr_reg(0, 2, 16'd0);
      wr_reg(0, 0, 16'd4);
      wr_reg(0, 1, 16'd2);
      wr_reg(0, 2, 16'd1);
      chk("pre_rst_out", 32'(out[0]), 1);
      chk("pre_rst_tick", 32'(tick[0]), 1);
      #1;
      resetq = 1'b0;
      #1;
      chk("arst_out", 32'(out), 0);
      chk("arst_tick", 32'(tick), 0);
      chk("arst_out3", 32'(out3), 0);
      @(negedge clk);
      resetq = 1'b1;
      for (int i = 0; i < 4; i++)
         for (int s = 0; s < 4; s++)
            rd_chk($sformatf("post_rst_rd%0d_%0d", i, s), i, s, 0);
      step();
      step();
      chk("post_rst_out", 32'(out), 0);
      chk("post_rst_tick", 32'(tick), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
